// File: rtl/alu_arbiter.sv
// alu_arbiter: two requesters share one combinational ALU through an IDLE/EXEC/RESP sequencer.
// Latency: accept at edge N, result captured at N+1, rsp_valid from the cycle after N+1; >=3 cycles between accepts.
// Backpressure: response held until rsp_ready; both readys stay low while an operation or response is outstanding.
// Build option ALU_ARB_RR_EN: round-robin when both request (default build: fixed priority, requester 0 wins).
module alu_arbiter #(
  parameter int DATA_W = 32,
  parameter int SEL_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [SEL_W-1:0]  req0_sel,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [SEL_W-1:0]  req1_sel,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [SEL_W-1:0]  alu_sel,
  input  logic [DATA_W-1:0] alu_res,
  input  logic              alu_zero,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_res,
  output logic              rsp_zero
);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

  state_t            state_q,   state_d;
  logic              gnt_id_q,  gnt_id_d;
  logic [DATA_W-1:0] alu_a_q,   alu_a_d;
  logic [DATA_W-1:0] alu_b_q,   alu_b_d;
  logic [SEL_W-1:0]  alu_sel_q, alu_sel_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_id_q,  rsp_id_d;
  logic [DATA_W-1:0] rsp_res_q, rsp_res_d;
  logic              rsp_zero_q, rsp_zero_d;
`ifdef ALU_ARB_RR_EN
  logic              last_gnt_q, last_gnt_d;
`endif

  logic pick;    // requester chosen this cycle (0 or 1)
  logic accept;

  // Arbitration: with a single requester it always wins; a tie is broken by the build option
  always_comb begin
    pick = ~req0_valid;
`ifdef ALU_ARB_RR_EN
    if (req0_valid && req1_valid) begin
      pick = ~last_gnt_q;
    end
`endif
  end

  // Grants only exist in IDLE and never while reset is held
  assign req0_ready = (state_q == IDLE) && !rst && req0_valid && !pick;
  assign req1_ready = (state_q == IDLE) && !rst && req1_valid &&  pick;
  assign accept     = req0_ready || req1_ready;

  // Sequencer next-state: latch operands on accept, capture ALU result after one EXEC cycle, hold response
  always_comb begin
    state_d     = state_q;
    gnt_id_d    = gnt_id_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_sel_d   = alu_sel_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_res_d   = rsp_res_q;
    rsp_zero_d  = rsp_zero_q;
`ifdef ALU_ARB_RR_EN
    last_gnt_d  = last_gnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          alu_a_d   = pick ? req1_a   : req0_a;
          alu_b_d   = pick ? req1_b   : req0_b;
          alu_sel_d = pick ? req1_sel : req0_sel;
          gnt_id_d  = pick;
`ifdef ALU_ARB_RR_EN
          last_gnt_d = pick;
`endif
          state_d   = EXEC;
        end
      end
      EXEC: begin
        rsp_res_d   = alu_res;
        rsp_zero_d  = alu_zero;
        rsp_id_d    = gnt_id_q;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset abandons any operation in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt_id_q    <= 1'b0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_sel_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_res_q   <= '0;
      rsp_zero_q  <= 1'b0;
`ifdef ALU_ARB_RR_EN
      last_gnt_q  <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      gnt_id_q    <= gnt_id_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_sel_q   <= alu_sel_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_res_q   <= rsp_res_d;
      rsp_zero_q  <= rsp_zero_d;
`ifdef ALU_ARB_RR_EN
      last_gnt_q  <= last_gnt_d;
`endif
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_sel   = alu_sel_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_res   = rsp_res_q;
  assign rsp_zero  = rsp_zero_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed vector table, hand-written multi-cycle sequences,
// and a randomized run scored against a transaction-level model (ALU = a + b).
`timescale 1ns/1ps
module tb_alu_arbiter;
  localparam int DW = 32;
  localparam int SW = 4;
`ifdef ALU_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_valid, req0_ready, req1_valid, req1_ready;
  logic [DW-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [SW-1:0] req0_sel, req1_sel;
  logic [DW-1:0] alu_a, alu_b, alu_res, rsp_res;
  logic [SW-1:0] alu_sel;
  logic          alu_zero, rsp_valid, rsp_ready, rsp_id, rsp_zero;

  int checks = 0;
  int errors = 0;

  alu_arbiter #(.DATA_W(DW), .SEL_W(SW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_res(alu_res), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_res(rsp_res), .rsp_zero(rsp_zero)
  );

  always #5 clk = ~clk;

  // Shared ALU stand-in
  assign alu_res  = alu_a + alu_b;
  assign alu_zero = (alu_res == '0);

  typedef struct {
    logic          v0, v1;
    logic [DW-1:0] a0, b0;
    logic [SW-1:0] s0;
    logic [DW-1:0] a1, b1;
    logic [SW-1:0] s1;
    logic          exp_id;
    logic [DW-1:0] exp_res;
    logic          exp_zero;
  } vec_t;

  typedef struct packed {
    logic          id;
    logic [DW-1:0] res;
    logic          zero;
  } rsp_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic clr_req();
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_sel = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_sel = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clr_req();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One transaction from a table row: accept, EXEC cycle, single-cycle response
  task automatic run_vec(input vec_t v, input string tag);
    int n;
    @(negedge clk);
    req0_valid = v.v0; req0_a = v.a0; req0_b = v.b0; req0_sel = v.s0;
    req1_valid = v.v1; req1_a = v.a1; req1_b = v.b1; req1_sel = v.s1;
    rsp_ready  = 1'b1;
    #2;
    n = 0;
    while (!((req0_valid && req0_ready) || (req1_valid && req1_ready)) && n < 20) begin
      @(negedge clk); #2; n++;
    end
    chk({tag, " accept"}, (n < 20), 1'b1);
    chk({tag, " single ready"}, req0_ready & req1_ready, 1'b0);
    chk({tag, " grant"}, req1_ready, v.exp_id);
    @(negedge clk);
    clr_req();
    req0_a = $urandom; req1_a = $urandom;   // operands change after the accept edge
    #2;
    chk({tag, " exec no rsp"}, rsp_valid, 1'b0);
    chk({tag, " alu_sel"}, alu_sel, v.exp_id ? v.s1 : v.s0);
    chk({tag, " alu_a"}, alu_a, v.exp_id ? v.a1 : v.a0);
    @(negedge clk); #2;
    chk({tag, " rsp_valid"}, rsp_valid, 1'b1);
    chk({tag, " rsp_id"}, rsp_id, v.exp_id);
    chk({tag, " rsp_res"}, rsp_res, v.exp_res);
    chk({tag, " rsp_zero"}, rsp_zero, v.exp_zero);
    @(negedge clk); #2;
    chk({tag, " rsp one cycle"}, rsp_valid, 1'b0);
    chk({tag, " alu_sel held"}, alu_sel, v.exp_id ? v.s1 : v.s0);
  endtask

  vec_t vecs[6];
  vec_t vr;
  rsp_t exp_q[$];
  rsp_t e;
  logic          pend[2];
  logic [DW-1:0] pa[2], pb[2];
  logic [SW-1:0] ps[2];
  logic          last_w, win, busy, seen_r1;
  logic          ids[4];
  int            gen_cnt, served, age, cnt, n;
  logic [DW-1:0] tmp;

  initial begin
    vecs[0] = '{1'b1, 1'b0, 32'd5, 32'd7, 4'd2, 32'd0, 32'd0, 4'd0, 1'b0, 32'd12, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 32'd0, 32'd0, 4'd0, 32'hFFFF_FFFF, 32'd1, 4'd9, 1'b1, 32'd0, 1'b1};
    vecs[2] = '{1'b1, 1'b0, 32'd0, 32'd0, 4'd15, 32'd0, 32'd0, 4'd0, 1'b0, 32'd0, 1'b1};
    vecs[3] = '{1'b0, 1'b1, 32'd0, 32'd0, 4'd0, 32'h8000_0000, 32'h8000_0000, 4'd3, 1'b1, 32'd0, 1'b1};
    // both valid after requester 1 was last served: requester 0 wins in either build
    vecs[4] = '{1'b1, 1'b1, 32'd1, 32'd2, 4'd4, 32'd10, 32'd20, 4'd5, 1'b0, 32'd3, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 32'd0, 32'd0, 4'd0, 32'd3, 32'd4, 4'd1, 1'b1, 32'd7, 1'b0};

    // Reset values, with both requesters asserting valid during reset
    rst = 1'b1; rsp_ready = 1'b1;
    clr_req();
    req0_valid = 1'b1; req1_valid = 1'b1;
    @(negedge clk); #2;
    chk("rst req0_ready", req0_ready, 1'b0);
    chk("rst req1_ready", req1_ready, 1'b0);
    chk("rst rsp_valid", rsp_valid, 1'b0);
    chk("rst rsp_id", rsp_id, 1'b0);
    chk("rst rsp_res", rsp_res, 32'd0);
    chk("rst rsp_zero", rsp_zero, 1'b0);
    chk("rst alu_a", alu_a, 32'd0);
    chk("rst alu_b", alu_b, 32'd0);
    chk("rst alu_sel", alu_sel, 4'd0);
    do_reset();

    for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Stalled response: held stable, no grants, then IDLE right after the handshake
    @(negedge clk);
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 32'd100; req0_b = 32'd23; req0_sel = 4'd6;
    #2;
    chk("stall accept r0", req0_ready, 1'b1);
    @(negedge clk);
    req0_valid = 1'b0; req0_a = 32'd0;
    req1_valid = 1'b1; req1_a = 32'd40; req1_b = 32'd2; req1_sel = 4'd1;
    #2;
    chk("stall exec r1 blocked", req1_ready, 1'b0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #2;
      chk("stall rsp_valid", rsp_valid, 1'b1);
      chk("stall rsp_res", rsp_res, 32'd123);
      chk("stall r1 blocked", req1_ready, 1'b0);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    #2;
    chk("stall release valid", rsp_valid, 1'b1);
    @(negedge clk); #2;
    chk("stall idle rsp_valid", rsp_valid, 1'b0);
    chk("stall idle r1 grant", req1_ready, 1'b1);
    @(negedge clk);
    clr_req();
    @(negedge clk); #2;
    chk("stall r1 rsp_id", rsp_id, 1'b1);
    chk("stall r1 rsp_res", rsp_res, 32'd42);

    // Reset during EXEC abandons the operation
    @(negedge clk);
    req0_valid = 1'b1; req0_a = 32'd9; req0_b = 32'd9; req0_sel = 4'd2;
    #2;
    chk("rstmid accept", req0_ready, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    #2;
    chk("rstmid rsp_valid", rsp_valid, 1'b0);
    chk("rstmid alu_a", alu_a, 32'd0);
    chk("rstmid alu_sel", alu_sel, 4'd0);
    chk("rstmid ready gated", req0_ready, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    clr_req();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #2;
      chk("rstmid no rsp", rsp_valid, 1'b0);
    end
    vr = '{1'b1, 1'b0, 32'd7, 32'd8, 4'd3, 32'd0, 32'd0, 4'd0, 1'b0, 32'd15, 1'b0};
    run_vec(vr, "post_rst");

    // Both requesters valid continuously from reset
    do_reset();
    @(negedge clk);
    rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd1; req0_sel = 4'd2;
    req1_valid = 1'b1; req1_a = 32'd2; req1_b = 32'd2; req1_sel = 4'd3;
    cnt = 0; n = 0; seen_r1 = 1'b0;
    while (cnt < 4 && n < 80) begin
      #2;
      if (req1_ready) seen_r1 = 1'b1;
      if (rsp_valid && rsp_ready) begin
        ids[cnt] = rsp_id;
        chk("both rsp_res", rsp_res, rsp_id ? 32'd4 : 32'd2);
        cnt++;
      end
      @(negedge clk);
      n++;
    end
    clr_req();
    chk("both rsp count", cnt, 4);
    for (int i = 0; i < 4; i++) chk($sformatf("both rsp_id[%0d]", i), ids[i], RR ? i[0] : 1'b0);
    chk("both r1 granted", seen_r1, RR);
    repeat (6) @(negedge clk);

    // Randomized traffic against a transaction-level model
    do_reset();
    last_w = 1'b1;
    pend[0] = 1'b0; pend[1] = 1'b0;
    gen_cnt = 0; served = 0; age = -1;
    for (int cyc = 0; cyc < 700; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (!pend[i] && cyc < 550 && $urandom_range(0, 2) == 0) begin
          pend[i] = 1'b1;
          pa[i] = $urandom;
          tmp = $urandom;
          pb[i] = ($urandom_range(0, 3) == 0) ? (32'd0 - pa[i]) : tmp;
          ps[i] = 4'($urandom_range(0, 15));
          gen_cnt++;
        end
      end
      req0_valid = pend[0]; req0_a = pa[0]; req0_b = pb[0]; req0_sel = ps[0];
      req1_valid = pend[1]; req1_a = pa[1]; req1_b = pb[1]; req1_sel = ps[1];
      rsp_ready = ($urandom_range(0, 3) != 0);
      #2;
      busy = (exp_q.size() > 0);
      win  = (pend[0] && pend[1]) ? (RR ? ~last_w : 1'b0) : pend[1];
      chk("rnd req0_ready", req0_ready, !busy && pend[0] && !win);
      chk("rnd req1_ready", req1_ready, !busy && pend[1] && win);
      if (age >= 0) age++;
      if (age == 1) chk("rnd exec no rsp", rsp_valid, 1'b0);
      if (age == 2) chk("rnd rsp latency", rsp_valid, 1'b1);
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          chk("rnd unexpected rsp", rsp_valid, 1'b0);
        end else begin
          chk("rnd rsp_id", rsp_id, exp_q[0].id);
          chk("rnd rsp_res", rsp_res, exp_q[0].res);
          chk("rnd rsp_zero", rsp_zero, exp_q[0].zero);
          if (rsp_ready) begin
            void'(exp_q.pop_front());
            served++;
          end
        end
      end
      for (int i = 0; i < 2; i++) begin
        if ((i == 0 && req0_valid && req0_ready) || (i == 1 && req1_valid && req1_ready)) begin
          e.id   = i[0];
          e.res  = pa[i] + pb[i];
          e.zero = (e.res == '0);
          exp_q.push_back(e);
          last_w  = i[0];
          pend[i] = 1'b0;
          age     = 0;
        end
      end
    end
    clr_req();
    chk("rnd all served", served, gen_cnt);
    chk("rnd queue empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter DATA_W, default 32, operand/result width.
REQ-002 Parameter SEL_W, default 4, ALU operation-select width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 req0_valid  input  1  requester 0 has an operation pending.
REQ-006 req0_ready  output  1  requester 0 operation accepted this cycle when high with req0_valid.
REQ-007 req0_a, req0_b  input  DATA_W  requester 0 operands.
REQ-008 req0_sel  input  SEL_W  requester 0 ALU operation code.
REQ-009 req1_valid, req1_ready, req1_a, req1_b, req1_sel  same directions/widths as requester 0, for requester 1.
REQ-010 alu_a, alu_b  output  DATA_W  operands driven to the shared ALU.
REQ-011 alu_sel  output  SEL_W  operation code driven to the shared ALU.
REQ-012 alu_res  input  DATA_W  combinational ALU result.
REQ-013 alu_zero  input  1  combinational ALU zero flag.
REQ-014 rsp_valid  output  1  response held for consumer.
REQ-015 rsp_ready  input  1  consumer accepts response.
REQ-016 rsp_id  output  1  requester that owns the response.
REQ-017 rsp_res  output  DATA_W; rsp_zero  output  1  captured result and zero flag.

Function
REQ-018 FSM states IDLE, EXEC, RESP; three states only.
REQ-019 IDLE: when any req valid, assert ready only to the granted requester (combinational); on valid&ready register a/b/sel into alu_a/alu_b/alu_sel, record grant id, go EXEC.
REQ-020 IDLE with no valid: stay IDLE, both readys low, ALU outputs hold last values.
REQ-021 EXEC: exactly one cycle; at its closing edge capture alu_res/alu_zero into rsp_res/rsp_zero, rsp_id := grant id, set rsp_valid, go RESP.
REQ-022 RESP: rsp_valid, rsp_id, rsp_res, rsp_zero held stable until rsp_valid&rsp_ready; on that edge clear rsp_valid, go IDLE.
REQ-023 Latency: handshake at edge N -> rsp_valid high in cycle after edge N+1; minimum 3 cycles between accepts.
REQ-024 readys low in EXEC and RESP regardless of req valids.
REQ-025 rsp_ready already high on RESP entry -> rsp_valid high exactly one cycle.
REQ-026 Requester not granted keeps valid asserted; block never drops or reorders a pending request; operands sampled only at accept edge.
REQ-027 Arbitration order defined in Configuration; decision made only in IDLE.

Reset
REQ-028 rst high: state IDLE, rsp_valid 0, rsp_id 0, rsp_res 0, rsp_zero 0, alu_a 0, alu_b 0, alu_sel 0, last-grant register 1, readys 0 while rst high.
REQ-029 rst asserted in EXEC or RESP abandons the operation; no response issued after release.
REQ-030 First cycle after rst release behaves as IDLE.

Configuration
REQ-031 Macro ALU_ARB_RR_EN defined: round-robin; both valid -> grant requester not granted last; last-grant updated each accept.
REQ-032 ALU_ARB_RR_EN undefined: fixed priority, requester 0 always wins when both valid; last-grant register absent.
REQ-033 Single-requester behaviour identical in both builds.

Verification (bench ALU model: alu_res = alu_a + alu_b, alu_zero = (alu_res == 0))
REQ-034 req0 only, a=5 b=7 sel=2, rsp_ready=1 -> accept edge N, rsp_valid one cycle after N+1 with rsp_res=12, rsp_zero=0, rsp_id=0.
REQ-035 req1 only, a=0xFFFFFFFF b=1 -> rsp_res=0, rsp_zero=1, rsp_id=1; alu_sel mirrors req1_sel.
REQ-036 Both valid continuously, rsp_ready=1, RR build -> rsp_id sequence 0,1,0,1; fixed build -> 0,0,0,0 with req1_ready never high.
REQ-037 rsp_ready=0 for 5 cycles in RESP -> rsp_valid/rsp_res stable, readys low, no new accept; rsp_ready=1 -> IDLE next cycle.
REQ-038 rst pulsed mid-EXEC -> all outputs reset values immediately, no rsp_valid after release, next req0 accept produces correct result.
REQ-039 Changing req0_a after accept edge -> rsp_res reflects value sampled at accept edge only.
